// File: rtl/intro_sequencer.sv
// Frame-paced intro controller: counts VGA frames and steps the platform, ladder and
// shield animations in order, raising done once the game may begin.
module intro_sequencer #(
    parameter int DROP_FRAMES    = 60,
    parameter int INCLINE_FRAMES = 60,
    parameter int LADDER_FRAMES  = 8,
    parameter int LADDER_COUNT   = 10,
    parameter int SHIELD_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_game,
    input  logic       abort,
    output logic       game_en,
    output logic       platform_ctl,
    output logic       incline_ctl,
    output logic       ladder_anim,
    output logic [3:0] ladder_cnt,
    output logic       shield_en,
    output logic       done
);

    localparam logic [7:0] DROP_LAST    = 8'(DROP_FRAMES - 1);
    localparam logic [7:0] INCLINE_LAST = 8'(INCLINE_FRAMES - 1);
    localparam logic [7:0] LADDER_LAST  = 8'(LADDER_FRAMES - 1);
    localparam logic [7:0] SHIELD_LAST  = 8'(SHIELD_FRAMES - 1);
    localparam logic [3:0] LADDER_MAX   = 4'(LADDER_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DROP,
        S_INCLINE,
        S_LADDERS,
        S_SHIELD,
        S_DONE
    } state_t;

    state_t     state_q;
    logic       vsync_q;
    logic [7:0] frame_cnt_q;
    logic [3:0] ladder_q;

    logic       frame_tick;
    logic [7:0] frame_last;
    logic [7:0] frame_inc;
    logic       phase_end;

    logic       game_en_d;
    logic       platform_ctl_d;
    logic       incline_ctl_d;
    logic       ladder_anim_d;
    logic [3:0] ladder_cnt_d;
    logic       shield_en_d;
    logic       done_d;

    // One pulse per frame, in the cycle after the vsync falling edge.
    assign frame_tick = vsync_q & ~vsync;
    assign frame_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
    assign phase_end  = frame_tick && (frame_cnt_q == frame_last);

    always_comb begin
        frame_last = 8'd0;
        case (state_q)
            S_DROP:    frame_last = DROP_LAST;
            S_INCLINE: frame_last = INCLINE_LAST;
            S_LADDERS: frame_last = LADDER_LAST;
            S_SHIELD:  frame_last = SHIELD_LAST;
            default:   frame_last = 8'd0;
        endcase
    end

    // Output levels follow the state register; they are registered one edge later.
    always_comb begin
        game_en_d      = 1'b0;
        platform_ctl_d = 1'b0;
        incline_ctl_d  = 1'b0;
        ladder_anim_d  = 1'b0;
        ladder_cnt_d   = 4'd0;
        shield_en_d    = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            S_DROP: begin
                game_en_d      = 1'b1;
                platform_ctl_d = 1'b1;
            end
            S_INCLINE: begin
                game_en_d      = 1'b1;
                platform_ctl_d = 1'b1;
                incline_ctl_d  = 1'b1;
            end
            S_LADDERS: begin
                game_en_d      = 1'b1;
                platform_ctl_d = 1'b1;
                incline_ctl_d  = 1'b1;
                ladder_anim_d  = 1'b1;
                ladder_cnt_d   = ladder_q;
            end
            S_SHIELD: begin
                game_en_d      = 1'b1;
                platform_ctl_d = 1'b1;
                incline_ctl_d  = 1'b1;
                ladder_cnt_d   = LADDER_MAX;
                shield_en_d    = 1'b1;
            end
            S_DONE: begin
                game_en_d      = 1'b1;
                platform_ctl_d = 1'b1;
                incline_ctl_d  = 1'b1;
                ladder_cnt_d   = LADDER_MAX;
                shield_en_d    = 1'b1;
                done_d         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end

        // abort shares the reset path so it wins over ticks and start_game alike.
        if (rst || abort) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= 8'd0;
            ladder_q     <= 4'd0;
            game_en      <= 1'b0;
            platform_ctl <= 1'b0;
            incline_ctl  <= 1'b0;
            ladder_anim  <= 1'b0;
            ladder_cnt   <= 4'd0;
            shield_en    <= 1'b0;
            done         <= 1'b0;
        end else begin
            game_en      <= game_en_d;
            platform_ctl <= platform_ctl_d;
            incline_ctl  <= incline_ctl_d;
            ladder_anim  <= ladder_anim_d;
            ladder_cnt   <= ladder_cnt_d;
            shield_en    <= shield_en_d;
            done         <= done_d;

            case (state_q)
                S_IDLE: begin
                    if (start_game) begin
                        state_q     <= S_DROP;
                        frame_cnt_q <= 8'd0;
                        ladder_q    <= 4'd0;
                    end
                end
                S_DROP: begin
                    if (phase_end) begin
                        state_q     <= S_INCLINE;
                        frame_cnt_q <= 8'd0;
                    end else if (frame_tick) begin
                        frame_cnt_q <= frame_inc;
                    end
                end
                S_INCLINE: begin
                    if (phase_end) begin
                        state_q     <= S_LADDERS;
                        frame_cnt_q <= 8'd0;
                        ladder_q    <= 4'd0;
                    end else if (frame_tick) begin
                        frame_cnt_q <= frame_inc;
                    end
                end
                S_LADDERS: begin
                    // A full ladder period after the last ladder appears moves on to the shield.
                    if (phase_end) begin
                        frame_cnt_q <= 8'd0;
                        if (ladder_q == LADDER_MAX) begin
                            state_q <= S_SHIELD;
                        end else begin
                            ladder_q <= ladder_q + 4'd1;
                        end
                    end else if (frame_tick) begin
                        frame_cnt_q <= frame_inc;
                    end
                end
                S_SHIELD: begin
                    if (phase_end) begin
                        state_q     <= S_DONE;
                        frame_cnt_q <= 8'd0;
                    end else if (frame_tick) begin
                        frame_cnt_q <= frame_inc;
                    end
                end
                S_DONE: begin
                    if (frame_tick) begin
                        frame_cnt_q <= frame_inc;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    frame_cnt_q <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intro_sequencer.sv
// Scoreboarded bench: two sequencers (short and default timing) share stimulus and are
// checked every cycle against a tick-count model of the intro timeline.
module tb_intro_sequencer;

    typedef struct packed {
        logic       game_en;
        logic       platform;
        logic       incline;
        logic       ladder_anim;
        logic [3:0] cnt;
        logic       shield;
        logic       done;
    } out_t;

    typedef struct packed {
        int d;
        int i;
        int l;
        int c;
        int s;
        bit active;
        int ticks;
        bit vprev;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, vsync = 1'b0, start_game = 1'b0, abort = 1'b0;

    logic       a_game_en, a_platform, a_incline, a_ladder_anim, a_shield, a_done;
    logic [3:0] a_cnt;
    logic       b_game_en, b_platform, b_incline, b_ladder_anim, b_shield, b_done;
    logic [3:0] b_cnt;

    intro_sequencer #(
        .DROP_FRAMES(2), .INCLINE_FRAMES(2), .LADDER_FRAMES(1),
        .LADDER_COUNT(3), .SHIELD_FRAMES(2)
    ) u_small (
        .clk(clk), .rst(rst), .vsync(vsync), .start_game(start_game), .abort(abort),
        .game_en(a_game_en), .platform_ctl(a_platform), .incline_ctl(a_incline),
        .ladder_anim(a_ladder_anim), .ladder_cnt(a_cnt), .shield_en(a_shield), .done(a_done)
    );

    intro_sequencer u_dflt (
        .clk(clk), .rst(rst), .vsync(vsync), .start_game(start_game), .abort(abort),
        .game_en(b_game_en), .platform_ctl(b_platform), .incline_ctl(b_incline),
        .ladder_anim(b_ladder_anim), .ladder_cnt(b_cnt), .shield_en(b_shield), .done(b_done)
    );

    out_t got_a, got_b;
    assign got_a = {a_game_en, a_platform, a_incline, a_ladder_anim, a_cnt, a_shield, a_done};
    assign got_b = {b_game_en, b_platform, b_incline, b_ladder_anim, b_cnt, b_shield, b_done};

    out_t q_a[$];
    out_t q_b[$];
    int checks = 0;
    int errors = 0;
    mdl_t ma, mb;

    // Timeline view: the phase is fixed purely by how many frames have passed since start.
    function automatic out_t decode(mdl_t m);
        out_t o;
        int n;
        o = '0;
        if (!m.active) return o;
        o.game_en  = 1'b1;
        o.platform = 1'b1;
        n = m.ticks;
        if (n < m.d) return o;
        o.incline = 1'b1;
        n = n - m.d;
        if (n < m.i) return o;
        n = n - m.i;
        if (n < m.l * (m.c + 1)) begin
            o.ladder_anim = 1'b1;
            o.cnt = 4'(n / m.l);
            return o;
        end
        n = n - m.l * (m.c + 1);
        o.cnt    = 4'(m.c);
        o.shield = 1'b1;
        if (n < m.s) return o;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic mdl_t advance(mdl_t m, logic r, logic ab, logic st, logic vs);
        mdl_t n;
        bit tick;
        n = m;
        tick = m.vprev && !vs;
        if (r || ab) begin
            n.active = 1'b0;
            n.ticks  = 0;
        end else if (!m.active) begin
            if (st) begin
                n.active = 1'b1;
                n.ticks  = 0;
            end
        end else if (tick && m.ticks < 100000) begin
            n.ticks = m.ticks + 1;
        end
        n.vprev = r ? 1'b0 : vs;
        return n;
    endfunction

    task automatic cyc();
        out_t ea, eb;
        ea = (rst || abort) ? out_t'(0) : decode(ma);
        eb = (rst || abort) ? out_t'(0) : decode(mb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        ma = advance(ma, rst, abort, start_game, vsync);
        mb = advance(mb, rst, abort, start_game, vsync);
        @(posedge clk);
        #1;
    endtask

    // mode 0: quiet, 1: stray start_game pulses, 2: random start/abort/rst
    task automatic frame(int mode);
        int hi, lo;
        hi = $urandom_range(1, 3);
        lo = $urandom_range(1, 3);
        for (int k = 0; k < hi + lo; k++) begin
            vsync = (k < hi);
            if (mode >= 1) start_game = ($urandom_range(0, 7) == 0);
            if (mode == 2) begin
                abort = ($urandom_range(0, 40) == 0);
                rst   = ($urandom_range(0, 150) == 0);
            end
            cyc();
        end
        start_game = 1'b0;
        abort      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic guard_check(string name, bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: wait bound expired, b_ticks=%0d required progress not reached", name, mb.ticks);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL small_sb: got=%b required=queued expectation (queue empty)", got_a);
            end else begin
                out_t e;
                e = q_a.pop_front();
                if (got_a !== e) begin
                    errors++;
                    $display("FAIL small t=%0t got=%b required=%b (en,plat,incl,anim,cnt4,shield,done)", $time, got_a, e);
                end
            end
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL dflt_sb: got=%b required=queued expectation (queue empty)", got_b);
            end else begin
                out_t e;
                e = q_b.pop_front();
                if (got_b !== e) begin
                    errors++;
                    $display("FAIL dflt t=%0t got=%b required=%b (en,plat,incl,anim,cnt4,shield,done)", $time, got_b, e);
                end
            end
        end
    end

    initial begin
        int g;
        ma = '{d: 2, i: 2, l: 1, c: 3, s: 2, active: 1'b0, ticks: 0, vprev: 1'b0};
        mb = '{d: 60, i: 60, l: 8, c: 10, s: 30, active: 1'b0, ticks: 0, vprev: 1'b0};
        #1;

        // Reset with vsync toggling, then idle frames that must not count.
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vsync = ~vsync;
            cyc();
        end
        rst = 1'b0;
        repeat (3) frame(0);

        $display("start: full intro run");
        start_game = 1'b1;
        cyc();
        start_game = 1'b0;
        g = 0;
        while (!decode(mb).done && g < 400) begin
            frame(1);
            g++;
        end
        guard_check("reach_done", decode(mb).done);

        $display("hold: done for 1000 frames with stray start_game");
        repeat (1000) frame(1);

        $display("abort mid-ladders on a frame tick");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        start_game = 1'b1;
        cyc();
        start_game = 1'b0;
        g = 0;
        while (mb.ticks < 165 && g < 400) begin
            frame(0);
            g++;
        end
        guard_check("reach_ladder5", decode(mb).cnt == 4'd5);
        vsync = 1'b1;
        repeat (2) cyc();
        vsync = 1'b0;
        abort = 1'b1;
        start_game = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        start_game = 1'b0;

        $display("rst during shield");
        g = 0;
        while (mb.ticks < 210 && g < 400) begin
            frame(0);
            g++;
        end
        guard_check("reach_shield", decode(mb).shield && !decode(mb).done);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vsync = ~vsync;
            cyc();
        end
        rst = 1'b0;
        repeat (3) frame(0);

        $display("random start/abort/rst traffic");
        repeat (300) frame(2);

        vsync = 1'b0;
        repeat (2) cyc();
        #3;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d/%0d leftover required=0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
